truth_sweep_checker: RTL and testbench
======================================

# truth_sweep_checker

Sequential stimulus-and-compare stage for the team's two-variant gate exercises: it sweeps every input vector into a structural implementation and a behavioural implementation of the same function, samples both results, and counts disagreements. It sits directly around the gate-pair stage. Its vector output feeds the `a`/`b` inputs of both variants, and it consumes their `s` outputs. It replaces hand-written `#1` stimulus sequences with a clocked, self-checking sweep.

## Interface
- `N_IN`, default 2: number of function inputs; vectors swept 0 .. 2^N_IN−1.
- `SETTLE`, default 1: cycles each vector is held before sampling; legal range ≥1.
- `clk`, input, 1: single clock, all state updates on rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a sweep; sampled only in IDLE or DONE.
- `vec_o`, output, N_IN: vector driven to both variants; bit 0 = variant input `a`, bit 1 = `b`.
- `res_a`, input, 1: output of structural variant.
- `res_b`, input, 1: output of behavioural variant.
- `busy`, output, 1: high in WAIT and CHECK.
- `done`, output, 1: high in DONE, held until next accepted `start` or reset.
- `pass`, output, 1: high in DONE iff `err_count`==0; 0 elsewhere.
- `err_count`, output, N_IN+1: mismatching vectors in current/last sweep.
- `fail_valid`, output, 1: a mismatch has been captured this sweep.
- `fail_vec`, output, N_IN: first mismatching vector; 0 when `fail_valid`=0.

## Operation
- States: IDLE, WAIT, CHECK, DONE.
- Reset values: state IDLE, `vec_o`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `fail_vec`=0, settle counter 0.
- IDLE/DONE + `start`=1: clear `err_count`, `fail_valid`, `fail_vec`, `done`; set `vec_o`=0, settle counter=0; go WAIT.
- WAIT: `vec_o` held; counter increments; at counter==SETTLE−1 go CHECK (WAIT lasts exactly SETTLE cycles).
- CHECK: mismatch = (`res_a`≠`res_b`). On mismatch: `err_count`+1; if `fail_valid`=0, latch `fail_vec`=`vec_o`, set `fail_valid`. Then if `vec_o`==2^N_IN−1 go DONE, `vec_o` stays at last vector; else `vec_o`+1, counter=0, go WAIT.
- `err_count` width N_IN+1 cannot overflow (max 2^N_IN); no wrap logic required, but counter saturates at all-ones as a guard.
- `start` during WAIT/CHECK: ignored, sweep unaffected.
- `reset` mid-sweep: all outputs return to reset values on that edge; no partial results retained.
- X/Z on `res_a`/`res_b` in CHECK counts as mismatch (case-inequality compare).

## Timing
- `start` accepted at edge k → `vec_o`=0 valid after edge k, `busy`=1.
- Per vector: SETTLE+1 cycles. Vector v is sampled at edge k + (v+1)(SETTLE+1).
- `done`=1, `busy`=0 after edge k + 2^N_IN·(SETTLE+1) (N_IN=2, SETTLE=1: 8 cycles).
- `err_count`/`fail_vec` update on the CHECK edge, visible the following cycle.
- `pass` valid exactly while `done`=1.
- Variants are combinational; SETTLE ≥1 guarantees one full cycle of propagation before sampling.

## Configuration
- `TRUTH_SWEEP_REF_EN` defined: adds input port `res_ref` (1 bit, expected value from a golden model); mismatch in CHECK becomes (`res_a`≠`res_b`) OR (`res_a`≠`res_ref`).
- Not defined: no `res_ref` port; mismatch is `res_a`≠`res_b` only.

## Test plan
- Reset then `start` pulse, N_IN=2, SETTLE=1, variants = ~(a&~b) structural and behavioural → `vec_o` steps 0,1,2,3; `done`=1 after 8 cycles, `pass`=1, `err_count`=0, `fail_valid`=0.
- Same, `res_b` forced to ~`res_a` only when `vec_o`=2 and 3 → `err_count`=2, `fail_vec`=2, `fail_valid`=1, `pass`=0.
- `res_b` always inverted → `err_count`=4 (100b), `fail_vec`=0.
- `start` pulsed again at cycle 3 of sweep → ignored; `done` still at cycle 8. `start` in DONE → new sweep, counters cleared the next cycle.
- `reset` asserted at cycle 5 → next cycle all outputs at reset values, state IDLE; subsequent `start` runs a full clean sweep.
- SETTLE=3 → each vector held 3 cycles; `done` after 16 cycles. With `TRUTH_SWEEP_REF_EN` and `res_ref` wrong at vector 1 only → `err_count`=1, `fail_vec`=1.

Source files
------------

// File: rtl/truth_sweep_checker.sv
// Clocked sweep-and-compare stage: drives every input vector into two gate variants and counts disagreements.
// Optional golden-reference input `res_ref` is enabled by defining TRUTH_SWEEP_REF_EN.
module truth_sweep_checker #(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic [N_IN-1:0] vec_o,
   input  logic            res_a,
   input  logic            res_b,
`ifdef TRUTH_SWEEP_REF_EN
   input  logic            res_ref,
`endif
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic            fail_valid,
   output logic [N_IN-1:0] fail_vec
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

   localparam int                CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
   localparam logic [N_IN-1:0]   LAST_VEC    = '1;
   localparam logic [N_IN-1:0]   VEC_ONE     = N_IN'(1);
   localparam logic [N_IN:0]     ERR_ONE     = (N_IN+1)'(1);
   localparam logic [N_IN:0]     ERR_MAX     = '1;

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] settle_cnt;
   logic             mismatch;

   // Case-inequality so that an X or Z from a variant is reported as a disagreement.
`ifdef TRUTH_SWEEP_REF_EN
   assign mismatch = (res_a !== res_b) || (res_a !== res_ref);
`else
   assign mismatch = (res_a !== res_b);
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE, S_DONE: if (start) next_state = S_WAIT;
         S_WAIT:         if (settle_cnt == SETTLE_LAST) next_state = S_CHECK;
         S_CHECK:        next_state = (vec_o == LAST_VEC) ? S_DONE : S_WAIT;
         default:        next_state = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == S_WAIT) || (state == S_CHECK);
      done = (state == S_DONE);
      pass = (state == S_DONE) && (err_count == '0);
   end

   // The first mismatching vector is kept for the whole sweep; later ones only bump the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         vec_o      <= '0;
         settle_cnt <= '0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= '0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  vec_o      <= '0;
                  settle_cnt <= '0;
                  err_count  <= '0;
                  fail_valid <= 1'b0;
                  fail_vec   <= '0;
               end
            end
            S_WAIT: settle_cnt <= settle_cnt + CNT_ONE;
            S_CHECK: begin
               if (mismatch) begin
                  if (err_count != ERR_MAX) err_count <= err_count + ERR_ONE;
                  if (!fail_valid) begin
                     fail_valid <= 1'b1;
                     fail_vec   <= vec_o;
                  end
               end
               if (vec_o != LAST_VEC) begin
                  vec_o      <= vec_o + VEC_ONE;
                  settle_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_sweep_checker.sv
// Self-checking bench: two sweep checkers (SETTLE=1 and SETTLE=3) share start/reset and are compared
// every cycle against an arithmetic model of sweep progress; variants are ~(a&~b) with per-vector fault masks.
module tb_truth_sweep_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b0;
   logic start = 1'b0;

   logic [1:0] vec1, vec3, fvec1, fvec3;
   logic       res_a1, res_b1, res_a3, res_b3;
   logic       busy1, done1, pass1, fval1, busy3, done3, pass3, fval3;
   logic [2:0] err1, err3;
   logic [3:0] mask1 = 4'b0000;
   logic [3:0] mask3 = 4'b0000;

   int compared   = 0;
   int mismatched = 0;

   bit started [2];
   int t_cnt   [2];

   function automatic logic gateFn(input logic [1:0] v);
      return ~(v[0] & ~v[1]);
   endfunction

   assign res_a1 = gateFn(vec1);
   assign res_b1 = gateFn(vec1) ^ mask1[vec1];
   assign res_a3 = gateFn(vec3);
   assign res_b3 = gateFn(vec3) ^ mask3[vec3];

`ifdef TRUTH_SWEEP_REF_EN
   logic [3:0] ref_mask1 = 4'b0000;
   logic [3:0] ref_mask3 = 4'b0000;
   logic       res_ref1, res_ref3;
   assign res_ref1 = gateFn(vec1) ^ ref_mask1[vec1];
   assign res_ref3 = gateFn(vec3) ^ ref_mask3[vec3];
`endif

   truth_sweep_checker #(.N_IN(2), .SETTLE(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .vec_o(vec1),
      .res_a(res_a1), .res_b(res_b1),
`ifdef TRUTH_SWEEP_REF_EN
      .res_ref(res_ref1),
`endif
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .fail_valid(fval1), .fail_vec(fvec1)
   );

   truth_sweep_checker #(.N_IN(2), .SETTLE(3)) dut3 (
      .clk(clk), .reset(reset), .start(start), .vec_o(vec3),
      .res_a(res_a3), .res_b(res_b3),
`ifdef TRUTH_SWEEP_REF_EN
      .res_ref(res_ref3),
`endif
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
      .fail_valid(fval3), .fail_vec(fvec3)
   );

   function automatic int settleOf(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   // A vector disagrees when the variants differ, or (with a reference) when a variant differs from it.
   function automatic logic [3:0] effMask(input int i);
      logic [3:0] m;
      m = (i == 0) ? mask1 : mask3;
`ifdef TRUTH_SWEEP_REF_EN
      m = m | ((i == 0) ? ref_mask1 : ref_mask3);
`endif
      return m;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic checkInst(input int i, input string nm, input logic [1:0] vec, input logic busy,
                            input logic done, input logic pass, input logic [2:0] err,
                            input logic fval, input logic [1:0] fvec);
      int per, total, tt, ev, errs, fv;
      bit fvalid, ebusy;
      logic [3:0] m;
      ev = 0; errs = 0; fv = 0; fvalid = 0; ebusy = 0;
      if (started[i]) begin
         per   = settleOf(i) + 1;
         total = 4 * per;
         tt    = t_cnt[i];
         m     = effMask(i);
         ebusy = (tt < total);
         ev    = ebusy ? tt / per : 3;
         for (int v = 0; v < 4; v++) begin
            if ((v + 1) * per <= tt && m[v]) begin
               if (!fvalid) fv = v;
               fvalid = 1;
               errs++;
            end
         end
      end
      checkOutput({nm, ".vec"},  32'(vec),  32'(ev));
      checkOutput({nm, ".busy"}, 32'(busy), 32'(ebusy));
      checkOutput({nm, ".done"}, 32'(done), 32'(started[i] && !ebusy));
      checkOutput({nm, ".pass"}, 32'(pass), 32'(started[i] && !ebusy && errs == 0));
      checkOutput({nm, ".err"},  32'(err),  32'(errs));
      checkOutput({nm, ".fval"}, 32'(fval), 32'(fvalid));
      checkOutput({nm, ".fvec"}, 32'(fvec), 32'(fv));
   endtask

   // One clock: drive inputs, advance the model at the edge, then compare both instances 1ns later.
   task automatic applyStimulus(input logic rst, input logic st);
      reset = rst;
      start = st;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            started[i] = 0;
            t_cnt[i]   = 0;
         end else if (st && (!started[i] || t_cnt[i] >= 4 * (settleOf(i) + 1))) begin
            started[i] = 1;
            t_cnt[i]   = 0;
         end else if (started[i]) begin
            t_cnt[i]++;
         end
      end
      #1;
      checkInst(0, "d1", vec1, busy1, done1, pass1, err1, fval1, fvec1);
      checkInst(1, "d3", vec3, busy3, done3, pass3, err3, fval3, fvec3);
   endtask

   task automatic runSweep(input int cycles);
      applyStimulus(1'b0, 1'b1);
      repeat (cycles - 1) applyStimulus(1'b0, 1'b0);
   endtask

   initial begin
      started = '{0, 0};
      t_cnt   = '{0, 0};

      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);

      // Clean sweep, then faults at vectors 2/3, then every vector inverted.
      runSweep(20);
      mask1 = 4'b1100; mask3 = 4'b1100;
      runSweep(20);
      mask1 = 4'b1111; mask3 = 4'b1111;
      runSweep(20);

      // Start during the sweep is ignored; start in DONE launches a new sweep.
      mask1 = 4'b0010; mask3 = 4'b0100;
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      repeat (5) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      repeat (20) applyStimulus(1'b0, 1'b0);

      // Reset mid-sweep, then a full clean sweep.
      mask1 = 4'b0000; mask3 = 4'b0000;
      applyStimulus(1'b0, 1'b1);
      repeat (4) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      repeat (2) applyStimulus(1'b0, 1'b0);
      runSweep(20);

`ifdef TRUTH_SWEEP_REF_EN
      ref_mask1 = 4'b0010; ref_mask3 = 4'b0010;
      runSweep(20);
      ref_mask1 = 4'b0000; ref_mask3 = 4'b0000;
`endif

      for (int s = 0; s < 8; s++) begin
         mask1 = 4'($urandom);
         mask3 = 4'($urandom);
`ifdef TRUTH_SWEEP_REF_EN
         ref_mask1 = 4'($urandom);
         ref_mask3 = 4'($urandom);
`endif
         applyStimulus(1'b0, 1'b1);
         for (int c = 1; c < 24; c++)
            applyStimulus(1'b0, (c < 12) && ($urandom_range(0, 5) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
